// File: rtl/slow_pulse_pacer.sv
// Fast-domain pacer: stretches single-cycle event strobes into PULSE_W-wide pulses with
// GAP_W low cycles between them, queueing early events. Optional: SLOW_PULSE_PACER_DROP_COUNT_EN.
module slow_pulse_pacer #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 4,
  parameter int PEND_W  = 4
) (
  input  logic              clk_fast,
  input  logic              rst_fast,
  input  logic              event_in,
  output logic              signal_fast,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
`ifdef SLOW_PULSE_PACER_DROP_COUNT_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t            state, state_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic [PEND_W-1:0] pending_nx;
  logic              req, consume, full, overflow_nx;

  assign req  = (pending != '0) || event_in;
  assign full = (pending == '1);
  assign busy = (state != IDLE) || (pending != '0);

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    consume  = 1'b0;
    case (state)
      IDLE: if (req) begin
        state_nx = HIGH;
        timer_nx = '0;
        consume  = 1'b1;
      end
      HIGH: if (timer == TW'(PULSE_W-1)) begin
        state_nx = GAP;
        timer_nx = '0;
      end else timer_nx = timer + TW'(1);
      GAP: if (timer == TW'(GAP_W-1)) begin
        timer_nx = '0;
        if (req) begin
          state_nx = HIGH;
          consume  = 1'b1;
        end else state_nx = IDLE;
      end else timer_nx = timer + TW'(1);
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  // an event coinciding with a consume is a pass-through, so it never counts as a drop
  always_comb begin
    pending_nx  = pending;
    overflow_nx = 1'b0;
    case ({event_in, consume})
      2'b10: if (full) overflow_nx = 1'b1;
             else      pending_nx  = pending + PEND_W'(1);
      2'b01: pending_nx = pending - PEND_W'(1);
      default: pending_nx = pending;
    endcase
  end

  always_ff @(posedge clk_fast or posedge rst_fast) begin
    if (rst_fast) begin
      state       <= IDLE;
      timer       <= '0;
      pending     <= '0;
      signal_fast <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      pending     <= pending_nx;
      signal_fast <= (state_nx == HIGH);
      overflow    <= overflow_nx;
    end
  end

`ifdef SLOW_PULSE_PACER_DROP_COUNT_EN
  always_ff @(posedge clk_fast or posedge rst_fast) begin
    if (rst_fast)                                  drop_count <= '0;
    else if (overflow_nx && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule
